// File: rtl/up_data_demux_pkg.sv
// Shared uplink word layout, sync default and demux FSM encodings.
// The transmit-side aggregator builds its words from the same struct.
package up_data_demux_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int         N_CH          = 4;
  localparam int         CH_W          = 2;
  localparam int         SEQ_W         = 8;
  localparam int         PAY_W         = 32;

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  // [63:56] sync, [55:50] rsvd, [49:48] ch_id, [47:40] seq, [39:32] rsvd, [31:0] payload
  typedef struct packed {
    logic [7:0]       sync;
    logic [5:0]       rsvd_hi;
    logic [CH_W-1:0]  ch;
    logic [SEQ_W-1:0] seq;
    logic [7:0]       rsvd_lo;
    logic [PAY_W-1:0] payload;
  } up_word_t;

  function automatic logic [N_CH-1:0] ch_onehot(input logic [CH_W-1:0] ch);
    return N_CH'(1) << ch;
  endfunction

endpackage

// File: rtl/up_data_demux_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones, 1-cycle update.
// No flow control: inc is sampled every cycle.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_q <= count_q + W'(1);
    end
  end

  assign q = count_q;

endmodule

// File: rtl/up_data_demux.sv
// Uplink receive demux: sync lock, per-channel steering and seq check; 1-cycle forward latency.
// No backpressure: every data_valid word is consumed, words outside LOCKED are dropped.
module up_data_demux
  import up_data_demux_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int         LOCK_CNT  = 2,
  parameter int         LOSS_CNT  = 3,
  parameter int         CNT_W     = 16,
  parameter int         TIMEOUT   = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    data_valid,
  input  logic [63:0]             up_data,
  output logic [N_CH-1:0]         ch_valid,
  output logic [PAY_W-1:0]        ch_data,
  output logic [SEQ_W-1:0]        ch_seq,
  output logic                    seq_err,
  output logic                    locked,
  output logic                    link_idle,
  output logic [N_CH*CNT_W-1:0]   frame_cnt,
  output logic [CNT_W-1:0]        seq_err_cnt,
  output logic [CNT_W-1:0]        sync_err_cnt
);

  localparam int GR_W = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
  localparam int BR_W = (LOSS_CNT > 1) ? $clog2(LOSS_CNT) : 1;
  localparam int IW   = $clog2(TIMEOUT + 1);

  up_word_t word;
  logic     sync_ok;
  logic     good_word;
  logic     bad_word;
  logic     fwd;
  logic     seq_bad;
  logic     unused_rsvd;

  state_e                       state_q;
  logic [GR_W-1:0]              good_run_q;
  logic [BR_W-1:0]              bad_run_q;
  logic                         locked_q;
  logic [N_CH-1:0]              ch_valid_q;
  logic [PAY_W-1:0]             ch_data_q;
  logic [SEQ_W-1:0]             ch_seq_q;
  logic                         seq_err_q;
  logic [N_CH-1:0][SEQ_W-1:0]   exp_q;
  logic [N_CH-1:0]              exp_vld_q;
  logic [IW-1:0]                idle_q;
  logic [IW-1:0]                idle_d;
  logic                         link_idle_q;

  assign word        = up_word_t'(up_data);
  assign unused_rsvd = ^{word.rsvd_hi, word.rsvd_lo};
  assign sync_ok     = (word.sync == SYNC_BYTE);
  assign good_word   = data_valid && sync_ok;
  assign bad_word    = data_valid && !sync_ok;
  assign fwd         = good_word && (state_q == ST_LOCKED);
  // An invalid expected entry never flags; it only seeds from the first forwarded word.
  assign seq_bad     = exp_vld_q[word.ch] && (word.seq != exp_q[word.ch]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_HUNT;
      good_run_q <= '0;
      bad_run_q  <= '0;
      locked_q   <= 1'b0;
      ch_valid_q <= '0;
      ch_data_q  <= '0;
      ch_seq_q   <= '0;
      seq_err_q  <= 1'b0;
      exp_q      <= '0;
      exp_vld_q  <= '0;
    end else begin
      ch_valid_q <= '0;
      seq_err_q  <= 1'b0;
      case (state_q)
        ST_HUNT: begin
          if (good_word) begin
            if (good_run_q == GR_W'(LOCK_CNT - 1)) begin
              state_q    <= ST_LOCKED;
              locked_q   <= 1'b1;
              good_run_q <= '0;
              bad_run_q  <= '0;
            end else begin
              good_run_q <= good_run_q + GR_W'(1);
            end
          end else if (bad_word) begin
            good_run_q <= '0;
          end
        end
        ST_LOCKED: begin
          if (good_word) begin
            bad_run_q          <= '0;
            ch_valid_q         <= ch_onehot(word.ch);
            ch_data_q          <= word.payload;
            ch_seq_q           <= word.seq;
            seq_err_q          <= seq_bad;
            exp_q[word.ch]     <= word.seq + SEQ_W'(1);
            exp_vld_q[word.ch] <= 1'b1;
          end else if (bad_word) begin
            if (bad_run_q == BR_W'(LOSS_CNT - 1)) begin
              state_q    <= ST_HUNT;
              locked_q   <= 1'b0;
              bad_run_q  <= '0;
              good_run_q <= '0;
              exp_vld_q  <= '0;
            end else begin
              bad_run_q <= bad_run_q + BR_W'(1);
            end
          end
        end
        default: begin
          state_q  <= ST_HUNT;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    idle_d = idle_q;
    if (data_valid) begin
      idle_d = '0;
    end else if (idle_q != IW'(TIMEOUT)) begin
      idle_d = idle_q + IW'(1);
    end
  end

  // Flag compares the next count so link_idle rises on the TIMEOUT-th idle edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_q      <= '0;
      link_idle_q <= 1'b0;
    end else begin
      idle_q      <= idle_d;
      link_idle_q <= (idle_d == IW'(TIMEOUT));
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_frame
    sat_counter #(.W(CNT_W)) u_frame_cnt (
      .clk (clk),
      .rst (rst),
      .inc (fwd && (word.ch == CH_W'(g))),
      .clr (1'b0),
      .q   (frame_cnt[g*CNT_W +: CNT_W])
    );
  end

  sat_counter #(.W(CNT_W)) u_seq_err_cnt (
    .clk (clk),
    .rst (rst),
    .inc (fwd && seq_bad),
    .clr (1'b0),
    .q   (seq_err_cnt)
  );

  sat_counter #(.W(CNT_W)) u_sync_err_cnt (
    .clk (clk),
    .rst (rst),
    .inc (bad_word),
    .clr (1'b0),
    .q   (sync_err_cnt)
  );

  assign ch_valid  = ch_valid_q;
  assign ch_data   = ch_data_q;
  assign ch_seq    = ch_seq_q;
  assign seq_err   = seq_err_q;
  assign locked    = locked_q;
  assign link_idle = link_idle_q;

endmodule

// File: tb/tb_up_data_demux.sv
// Bench for up_data_demux: scoreboarded forwarding plus lock, idle, counter and reset checks.
module tb_up_data_demux;

  localparam logic [7:0] SYNC     = 8'hA5;
  localparam int         LOCK_CNT = 2;
  localparam int         LOSS_CNT = 3;

  typedef struct {
    logic [3:0]  v;
    logic [31:0] d;
    logic [7:0]  s;
    logic        e;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_valid;
  logic [63:0] up_data;

  logic [3:0]  ch_valid;
  logic [31:0] ch_data;
  logic [7:0]  ch_seq;
  logic        seq_err, locked, link_idle;
  logic [63:0] frame_cnt;
  logic [15:0] seq_err_cnt, sync_err_cnt;

  logic [3:0]  s_ch_valid;
  logic [31:0] s_ch_data;
  logic [7:0]  s_ch_seq;
  logic        s_seq_err, s_locked, s_link_idle;
  logic [15:0] s_frame_cnt;
  logic [3:0]  s_seq_err_cnt, s_sync_err_cnt;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  exp_t sb[$];
  exp_t mon_e;

  bit         m_locked;
  int         m_good, m_bad;
  logic [7:0] m_exp [4];
  bit         m_vld [4];

  up_data_demux u_dut (
    .clk(clk), .rst(rst), .data_valid(data_valid), .up_data(up_data),
    .ch_valid(ch_valid), .ch_data(ch_data), .ch_seq(ch_seq), .seq_err(seq_err),
    .locked(locked), .link_idle(link_idle), .frame_cnt(frame_cnt),
    .seq_err_cnt(seq_err_cnt), .sync_err_cnt(sync_err_cnt)
  );

  up_data_demux #(.CNT_W(4)) u_dut_sat (
    .clk(clk), .rst(rst), .data_valid(data_valid), .up_data(up_data),
    .ch_valid(s_ch_valid), .ch_data(s_ch_data), .ch_seq(s_ch_seq), .seq_err(s_seq_err),
    .locked(s_locked), .link_idle(s_link_idle), .frame_cnt(s_frame_cnt),
    .seq_err_cnt(s_seq_err_cnt), .sync_err_cnt(s_sync_err_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_locked = 1'b0;
    m_good   = 0;
    m_bad    = 0;
    for (int i = 0; i < 4; i++) begin
      m_exp[i] = 8'h00;
      m_vld[i] = 1'b0;
    end
    sb.delete();
  endtask

  task automatic send(input logic [7:0] sync, input logic [1:0] ch,
                      input logic [7:0] seq, input logic [31:0] pay);
    exp_t e;
    @(posedge clk); #1;
    data_valid = 1'b1;
    up_data    = {sync, 6'($urandom), ch, seq, 8'($urandom), pay};
    if (sync == SYNC) begin
      if (!m_locked) begin
        m_good++;
        if (m_good == LOCK_CNT) begin
          m_locked = 1'b1;
          m_good   = 0;
        end
      end else begin
        m_bad = 0;
        e.v   = 4'b0001 << ch;
        e.d   = pay;
        e.s   = seq;
        e.e   = m_vld[ch] && (seq != m_exp[ch]);
        e.cyc = cyc + 1;
        sb.push_back(e);
        m_exp[ch] = seq + 8'd1;
        m_vld[ch] = 1'b1;
      end
    end else begin
      m_good = 0;
      if (m_locked) begin
        m_bad++;
        if (m_bad == LOSS_CNT) begin
          m_locked = 1'b0;
          m_bad    = 0;
          for (int i = 0; i < 4; i++) m_vld[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic drop();
    @(posedge clk); #1;
    data_valid = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ch_valid"}, ch_valid, 0);
    check({tag, "_ch_data"}, ch_data, 0);
    check({tag, "_ch_seq"}, ch_seq, 0);
    check({tag, "_seq_err"}, seq_err, 0);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_link_idle"}, link_idle, 0);
    check({tag, "_frame_cnt"}, frame_cnt, 0);
    check({tag, "_seq_err_cnt"}, seq_err_cnt, 0);
    check({tag, "_sync_err_cnt"}, sync_err_cnt, 0);
    check({tag, "_sat_frame_cnt"}, s_frame_cnt, 0);
    check({tag, "_sat_locked"}, s_locked, 0);
  endtask

  // Scoreboard: every forwarded word must match the oldest prediction, one cycle after it was driven.
  always @(negedge clk) begin
    if (!rst) begin
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
        mon_e = sb.pop_front();
        check("fwd_missing", 64'(cyc), 64'(mon_e.cyc));
      end
      if (ch_valid != 4'b0000) begin
        if (sb.size() == 0) begin
          check("fwd_unexpected", ch_valid, 0);
        end else begin
          mon_e = sb.pop_front();
          check("fwd_cycle", 64'(cyc), 64'(mon_e.cyc));
          check("fwd_ch_valid", ch_valid, mon_e.v);
          check("fwd_ch_data", ch_data, mon_e.d);
          check("fwd_ch_seq", ch_seq, mon_e.s);
          check("fwd_seq_err", seq_err, mon_e.e);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    data_valid = 1'b0;
    up_data    = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_zero("reset");

    // Lock on two good words; the third is the first forwarded one
    send(SYNC, 2'd0, 8'd0, 32'h1000_0000);
    send(SYNC, 2'd0, 8'd1, 32'h1000_0001);
    @(negedge clk);
    check("lock_after_1", locked, 0);
    send(SYNC, 2'd0, 8'd2, 32'h1000_0002);
    @(negedge clk);
    check("lock_after_2", locked, 1);
    drop();
    @(negedge clk);
    check("t1_frame_cnt0", frame_cnt[15:0], 16'd1);

    // ch2 sequence gap
    send(SYNC, 2'd2, 8'd10, 32'h2000_000A);
    send(SYNC, 2'd2, 8'd11, 32'h2000_000B);
    send(SYNC, 2'd2, 8'd13, 32'h2000_000D);
    send(SYNC, 2'd2, 8'd14, 32'h2000_000E);
    drop();
    @(negedge clk);
    check("t2_seq_err_cnt", seq_err_cnt, 16'd1);
    check("t2_frame_cnt2", frame_cnt[47:32], 16'd4);

    // ch1 seq wraps 255 -> 0
    send(SYNC, 2'd1, 8'd254, 32'hDEAD_BEEF);
    send(SYNC, 2'd1, 8'd255, 32'hCAFE_F00D);
    send(SYNC, 2'd1, 8'd0,   32'h0123_4567);
    drop();
    @(posedge clk);
    @(negedge clk);
    check("t3_hold_valid", ch_valid, 0);
    check("t3_hold_data", ch_data, 32'h0123_4567);
    check("t3_seq_err_cnt", seq_err_cnt, 16'd1);

    // Bad-sync runs: a good word between runs restarts the loss count
    send(8'h00, 2'd0, 8'd0, 32'h0);
    send(8'h00, 2'd0, 8'd0, 32'h0);
    send(SYNC,  2'd0, 8'd3, 32'h3000_0003);
    @(negedge clk);
    check("t4_locked_run1", locked, 1);
    send(8'h00, 2'd0, 8'd0, 32'h0);
    send(8'h00, 2'd0, 8'd0, 32'h0);
    @(negedge clk);
    check("t4_locked_bad1", locked, 1);
    send(8'h00, 2'd0, 8'd0, 32'h0);
    @(negedge clk);
    check("t4_locked_bad2", locked, 1);
    drop();
    @(negedge clk);
    check("t4_hunt", locked, 0);
    check("t4_sync_err_cnt", sync_err_cnt, 16'd5);
    // Expected seqs were invalidated, so ch2 seq 99 must not flag
    send(SYNC, 2'd0, 8'd50, 32'h4000_0000);
    send(SYNC, 2'd0, 8'd51, 32'h4000_0001);
    send(SYNC, 2'd2, 8'd99, 32'h4000_0063);
    drop();
    @(negedge clk);
    check("t4_relock", locked, 1);
    check("t4_seq_err_cnt", seq_err_cnt, 16'd1);

    // Idle timeout
    send(SYNC, 2'd0, 8'd7, 32'h5000_0007);
    drop();
    repeat (63) @(posedge clk);
    @(negedge clk);
    check("t5_idle_63", link_idle, 0);
    @(posedge clk);
    @(negedge clk);
    check("t5_idle_64", link_idle, 1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("t5_idle_hold", link_idle, 1);
    check("t5_still_locked", locked, 1);
    send(SYNC, 2'd0, 8'd8, 32'h5000_0008);
    drop();
    @(negedge clk);
    check("t5_idle_clear", link_idle, 0);

    // Saturation at CNT_W=4, then asynchronous reset mid-word
    for (int i = 0; i < 20; i++) begin
      send(SYNC, 2'd3, 8'(i), 32'h6000_0000 + 32'(i));
    end
    drop();
    @(negedge clk);
    check("t6_sat_frame_cnt3", s_frame_cnt[15:12], 4'hF);
    check("t6_frame_cnt3", frame_cnt[63:48], 16'd20);
    send(SYNC, 2'd3, 8'd20, 32'h6000_0014);
    #2;
    rst        = 1'b1;
    data_valid = 1'b0;
    model_clear();
    #1;
    check_zero("midrst");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    send(SYNC, 2'd1, 8'd0, 32'h7000_0000);
    drop();
    @(negedge clk);
    check("post_rst_hunt", locked, 0);
    check("post_rst_frame_cnt", frame_cnt, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("sb_drain", 64'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
